// File: rtl/stream_descrambler.sv
// Receive-side descrambler for the x^33 + x^13 + 1 side-stream scrambler.
// Acquires keystream lock from idle bits, verifies it, then descrambles and monitors idle errors.
module stream_descrambler #(
    parameter int VERIFY_LEN = 64,
    parameter int ERR_MAX    = 8,
    parameter int WINDOW     = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       valid,
    input  logic       rx_bit,
    input  logic       rx_idle,
    output logic       data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       lock_lost,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ACQ,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [9:0]  MATCH_LAST = 10'(VERIFY_LEN - 1);
    localparam logic [7:0]  ERR_LIMIT  = 8'(ERR_MAX);
    localparam logic [15:0] WIN_LEN    = 16'(WINDOW);

    state_t      state, state_n;
    logic [32:0] lfsr, lfsr_n;
    logic [5:0]  acq_cnt, acq_cnt_n;
    logic [9:0]  match_cnt, match_cnt_n;
    logic [15:0] win_cnt, win_cnt_n;
    logic [7:0]  err_cnt_n;
    logic        data_out_n, data_valid_n, lock_lost_n;
    logic        p, d;
    logic [7:0]  err_inc;
    logic [15:0] win_inc;

    // p is the predicted keystream bit; d is the descrambled bit (nonzero on an idle mismatch).
    assign p       = lfsr[32] ^ lfsr[12];
    assign d       = rx_bit ^ p;
    assign err_inc = err_cnt + {7'd0, d};
    assign win_inc = win_cnt + 16'd1;
    assign locked  = (state == LOCKED);

    always_comb begin
        state_n      = state;
        lfsr_n       = lfsr;
        acq_cnt_n    = acq_cnt;
        match_cnt_n  = match_cnt;
        win_cnt_n    = win_cnt;
        err_cnt_n    = err_cnt;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        lock_lost_n  = 1'b0;

        if (load) begin
            state_n     = ACQ;
            acq_cnt_n   = '0;
            match_cnt_n = '0;
            win_cnt_n   = '0;
            err_cnt_n   = '0;
        end else if (valid) begin
            case (state)
                ACQ: begin
                    lfsr_n = {lfsr[31:0], rx_bit};
                    if (acq_cnt == 6'd32) begin
                        state_n     = VERIFY;
                        acq_cnt_n   = '0;
                        match_cnt_n = '0;
                    end else begin
                        acq_cnt_n = acq_cnt + 6'd1;
                    end
                end
                // A mismatching bit is dropped so the refill starts on the next received bit.
                VERIFY: begin
                    if (d) begin
                        state_n   = ACQ;
                        acq_cnt_n = '0;
                    end else begin
                        lfsr_n = {lfsr[31:0], p};
                        if (match_cnt == MATCH_LAST) begin
                            state_n     = LOCKED;
                            match_cnt_n = '0;
                            err_cnt_n   = '0;
                            win_cnt_n   = '0;
                        end else begin
                            match_cnt_n = match_cnt + 10'd1;
                        end
                    end
                end
                LOCKED: begin
                    lfsr_n       = {lfsr[31:0], p};
                    data_out_n   = d;
                    data_valid_n = 1'b1;
                    if (rx_idle) begin
                        // Loss of lock takes precedence over the window closing on the same bit.
                        if (d && (err_inc == ERR_LIMIT)) begin
                            state_n     = ACQ;
                            lock_lost_n = 1'b1;
                            err_cnt_n   = '0;
                            win_cnt_n   = '0;
                            acq_cnt_n   = '0;
                        end else if (win_inc == WIN_LEN) begin
                            win_cnt_n = '0;
                            err_cnt_n = '0;
                        end else begin
                            win_cnt_n = win_inc;
                            err_cnt_n = err_inc;
                        end
                    end
                end
                default: state_n = ACQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACQ;
            lfsr       <= '0;
            acq_cnt    <= '0;
            match_cnt  <= '0;
            win_cnt    <= '0;
            err_cnt    <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            acq_cnt    <= acq_cnt_n;
            match_cnt  <= match_cnt_n;
            win_cnt    <= win_cnt_n;
            err_cnt    <= err_cnt_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            lock_lost  <= lock_lost_n;
        end
    end

endmodule

// File: tb/tb_stream_descrambler.sv
// Testbench for stream_descrambler: a transmit scrambler feeds the DUT and a bit-count
// model of acquisition, verification and idle-error monitoring predicts every output.
module tb_stream_descrambler;

    localparam int VLEN      = 64;
    localparam int EMAX      = 8;
    localparam int WIN       = 256;
    localparam int LOCK_BITS = 33 + VLEN;

    logic       clk, rst_n, load, valid, rx_bit, rx_idle;
    logic       data_out, data_valid, locked, lock_lost;
    logic [7:0] err_cnt;
    logic [11:0] observed;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] sc;
    int   m_bits, m_err, m_win;
    logic m_locked, m_ll, m_dv, m_dout;

    stream_descrambler #(.VERIFY_LEN(VLEN), .ERR_MAX(EMAX), .WINDOW(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .valid(valid), .rx_bit(rx_bit),
        .rx_idle(rx_idle), .data_out(data_out), .data_valid(data_valid),
        .locked(locked), .lock_lost(lock_lost), .err_cnt(err_cnt)
    );

    assign observed = {locked, lock_lost, data_valid, data_out, err_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [11:0] expected();
        return {m_locked, m_ll, m_dv, m_dout, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_bits = 0; m_err = 0; m_win = 0;
        m_locked = 1'b0; m_ll = 1'b0; m_dv = 1'b0; m_dout = 1'b0;
    endtask

    // Drive one cycle: the scrambler advances on every valid bit, and the model tracks
    // how many clean bits have been seen since acquisition restarted.
    task automatic step(input logic v, input logic ld, input logic plain,
                        input logic idle, input logic flip);
        logic k;
        k       = sc[32] ^ sc[12];
        load    = ld;
        valid   = v;
        rx_idle = idle;
        rx_bit  = v ? (plain ^ k ^ flip) : 1'($urandom_range(0, 1));
        if (v) sc = {sc[31:0], k};
        m_dv = 1'b0;
        m_ll = 1'b0;
        if (ld) begin
            m_bits = 0; m_locked = 1'b0; m_err = 0; m_win = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (m_bits >= 33 && flip) begin
                    m_bits = 0;
                end else begin
                    m_bits++;
                    if (m_bits == LOCK_BITS) begin
                        m_locked = 1'b1; m_err = 0; m_win = 0;
                    end
                end
            end else begin
                m_dout = plain ^ flip;
                m_dv   = 1'b1;
                if (idle) begin
                    m_win++;
                    if (flip) m_err++;
                    if (flip && m_err == EMAX) begin
                        m_locked = 1'b0; m_ll = 1'b1; m_err = 0; m_win = 0; m_bits = 0;
                    end else if (m_win == WIN) begin
                        m_win = 0; m_err = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; valid = 1'b0; rx_bit = 1'b0; rx_idle = 1'b0;
        sc = 33'h1_0000_0001;
        model_reset();
        #12;
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL reset_state: got %h expected %h", observed, expected());
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_lock();
        int lock_at = -1;
        for (int i = 1; i <= 200; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL idle_lock bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
            if (locked && lock_at < 0) lock_at = i;
        end
        n_checks++;
        if (lock_at !== LOCK_BITS)
            $display("[TB] FAIL idle_lock_point: got %0d expected %0d", lock_at, LOCK_BITS);
        else n_pass++;
    endtask

    task automatic test_data();
        logic v, plain;
        for (int i = 0; i < 1000; i++) begin
            v     = ($urandom_range(0, 99) >= 30);
            plain = 1'($urandom);
            step(v, 1'b0, plain, 1'b0, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL data cycle %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
        end
    endtask

    task automatic test_verify_fail();
        int relock_at = -1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL verify_load: got %h expected %h", observed, expected());
        else n_pass++;
        for (int i = 1; i <= 43; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, i == 43);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL verify_fill bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
        end
        for (int j = 1; j <= 120; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL verify_reacq bit %0d: got %h expected %h", j, observed, expected());
            else n_pass++;
            if (locked && relock_at < 0) relock_at = j;
        end
        n_checks++;
        if (relock_at !== LOCK_BITS)
            $display("[TB] FAIL verify_relock_point: got %0d expected %0d", relock_at, LOCK_BITS);
        else n_pass++;
    endtask

    task automatic test_loss_of_lock();
        int ll_count = 0;
        int fell_at  = -1;
        for (int i = 1; i <= 250; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, (i <= 100) && (i % 12 == 5));
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL loss bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
            if (lock_lost) ll_count++;
            if (!locked && fell_at < 0) fell_at = i;
        end
        n_checks++;
        if (fell_at !== 89)
            $display("[TB] FAIL loss_fall_point: got %0d expected 89", fell_at);
        else n_pass++;
        n_checks++;
        if (ll_count !== 1)
            $display("[TB] FAIL loss_pulse_count: got %0d expected 1", ll_count);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1)
            $display("[TB] FAIL loss_relock: got %b expected 1", locked);
        else n_pass++;
    endtask

    task automatic test_window_clear();
        int   guard = 0;
        int   drops = 0;
        logic [7:0] prev;
        logic flip;
        while (m_win != 0 && guard < 300) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL window_align %0d: got %h expected %h", guard, observed, expected());
            else n_pass++;
        end
        prev = err_cnt;
        for (int i = 0; i < 4 * WIN; i++) begin
            flip = (m_win >= 20) && (m_win <= 200) && ((m_win - 20) % 30 == 0);
            step(1'b1, 1'b0, 1'b0, 1'b1, flip);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL window bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
            if (prev != 8'd0 && err_cnt == 8'd0) drops++;
            prev = err_cnt;
        end
        n_checks++;
        if (drops !== 4)
            $display("[TB] FAIL window_clears: got %0d expected 4", drops);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1)
            $display("[TB] FAIL window_locked: got %b expected 1", locked);
        else n_pass++;
    endtask

    task automatic test_load();
        int ll_count = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL load_locked: got %h expected %h", observed, expected());
        else n_pass++;
        for (int i = 1; i <= 120; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL load_reacq bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
            if (lock_lost) ll_count++;
        end
        n_checks++;
        if (ll_count !== 0)
            $display("[TB] FAIL load_no_lock_lost: got %0d expected 0", ll_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL areset_pre: got %h expected %h", observed, expected());
        else n_pass++;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL areset_locked: got %h expected %h", observed, expected());
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL areset_fill bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (observed !== expected())
            $display("[TB] FAIL areset_verify: got %h expected %h", observed, expected());
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (observed !== expected())
                $display("[TB] FAIL areset_reacq bit %0d: got %h expected %h", i, observed, expected());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_lock();
        test_data();
        test_verify_fail();
        test_loss_of_lock();
        test_window_clear();
        test_load();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_descrambler.md
# stream_descrambler

Receive-side counterpart of the side-stream scrambler (polynomial x^33 + x^13 + 1) in the 100BASE-T1 PCS path. It consumes one scrambled bit per valid cycle and acquires keystream lock by loading its 33-bit LFSR from received idle bits, which are scrambled zeros. It then verifies the lock and descrambles the stream, monitoring idle periods so that it can declare loss of lock and re-acquire. It sits between the PMA bit recovery and the PCS decoder.

## Interface
- VERIFY_LEN, 64: consecutive matching bits needed in VERIFY before lock is declared (1..1023).
- ERR_MAX, 8: idle-bit mismatches within one window that force loss of lock (1..255).
- WINDOW, 256: idle bits per error-monitoring window (ERR_MAX..65535).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  synchronous restart of acquisition, active high.
- valid  in  1  rx_bit is meaningful this cycle.
- rx_bit  in  1  received scrambled bit.
- rx_idle  in  1  qualifies rx_bit as an idle bit (plaintext is 0); sampled only with valid.
- data_out  out  1  descrambled bit, registered.
- data_valid  out  1  data_out is meaningful; pulses only in LOCKED.
- locked  out  1  high while FSM is in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->ACQ transition.
- err_cnt  out  8  idle mismatches in the current window.

## Operation
- LFSR s[32:0]; predicted keystream bit p = s[32] ^ s[12]. Normal advance: s <= {s[31:0], p}. This is bit-identical to the transmit scrambler.
- The FSM has three states: ACQ, VERIFY, LOCKED. A cycle without valid (and without load) changes no state, counter, or LFSR.
- ACQ:
  - Each valid bit: s <= {s[31:0], rx_bit}; acq_cnt increments.
  - When the 33rd bit is taken, go to VERIFY with match_cnt = 0.
- VERIFY:
  - Each valid bit: advance normally and compare rx_bit with p.
  - Mismatch: go to ACQ with acq_cnt = 0. The mismatching bit is discarded and not shifted in.
  - Match: match_cnt increments. The VERIFY_LEN-th match moves the FSM to LOCKED and clears err_cnt and win_cnt.
  - rx_idle is ignored in ACQ and VERIFY; the received stream is treated as idle.
- LOCKED:
  - Each valid bit: advance normally; data_out <= rx_bit ^ p; data_valid <= 1.
  - If rx_idle=1: win_cnt increments, and err_cnt increments when rx_bit ^ p = 1.
  - If the increment makes err_cnt equal ERR_MAX: go to ACQ, lock_lost pulses, and err_cnt, win_cnt, and acq_cnt clear.
  - Otherwise, if win_cnt reaches WINDOW: win_cnt and err_cnt clear.
  - If err_cnt reaching ERR_MAX and the window closing happen on the same bit, loss of lock wins.
- load=1 in any state: go to ACQ; all counters clear; data_valid, locked, and lock_lost go to 0. The LFSR is not cleared; it refills in ACQ. load has priority over valid, and the coincident bit is discarded.
- Reset: state ACQ; s, all counters, data_out, data_valid, locked, lock_lost, and err_cnt are all 0.

## Timing
- Descramble latency is 1 cycle: a valid bit at edge k produces data_out/data_valid visible after edge k.
- data_valid is 0 in every cycle following an edge where valid=0 or the state was not LOCKED. data_out holds its last value when data_valid is 0.
- locked rises after the edge that consumes the VERIFY_LEN-th matching bit. The minimum time from reset release is 33 + VERIFY_LEN valid bits.
- The first data_valid comes with the first valid bit after locked rises. The bit that completes verification is not output.
- locked falls and lock_lost pulses after the edge that consumes the ERR_MAX-th idle mismatch. That bit's data_out is still produced with data_valid=1.
- Asynchronous reset mid-operation clears immediately and does not depend on clk.

## Test plan
- Reset then idle:
  - Stimulus: the bench scrambler is seeded with 33'h1_0000_0001; send 200 continuous valid idle bits (keystream), rx_idle=1.
  - Required: locked rises after bit 97 (33 + 64); data_out = 0 with data_valid = 1 from bit 98 on; err_cnt stays 0.
- Data after lock:
  - Stimulus: after lock, send 1000 random plaintext bits XORed with keystream, rx_idle=0, with valid randomly deasserted 30% of the time.
  - Required: data_out equals the plaintext bit-for-bit; no data_valid in valid-low cycles.
- Verify failure:
  - Stimulus: flip rx_bit at VERIFY bit 10.
  - Required: FSM returns to ACQ, locked stays 0, and lock is gained 33 + 64 bits after the flipped bit.
- Loss of lock:
  - Stimulus: when locked, flip 8 idle bits within 100 idle bits.
  - Required: err_cnt reaches 8, lock_lost pulses once, locked falls on the 8th flip, and the block re-locks on continued clean idle.
- Window clear:
  - Stimulus: flip 7 idle bits per 256-bit window for 4 windows.
  - Required: locked stays 1; err_cnt returns to 0 at each window boundary.
- Load and reset:
  - Stimulus: assert load together with valid while LOCKED; separately, pulse rst_n low mid-VERIFY between clock edges.
  - Required: with load, locked and data_valid go to 0 and acquisition restarts with no lock_lost pulse. With reset, all outputs go to 0 immediately.
